// File: rtl/img_bram_arb.sv
// img_bram_arb
// Shares one single-port image BRAM between three requesters:
//   - video reader: absolute priority, never stalled, combinational pass-through
//   - pixel loader: write port with valid/ready handshake
//   - aux readback: valid/ready request, tagged fixed-latency response
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   vid_en_i/vid_addr_i          video read request and address
//   vid_data_o                   video read data (raw BRAM read data)
//   s_wr_valid/ready/addr/data   loader write channel
//   s_ar_valid/ready/addr        aux read request channel
//   m_r_valid/m_r_data           aux read response (no backpressure)
//   bram_*                       single BRAM port
//   wr_starved_o                 write pending without grant for STARVE_CYC cycles
//   addr_err_o                   sticky out-of-range accept flag
//   wr_cnt_o                     wrapping count of accepted in-range writes
module img_bram_arb #(
  parameter int ADDRW      = 17,
  parameter int DATAW      = 24,
  parameter int DEPTH      = 76800,
  parameter int RD_LAT     = 1,
  parameter int STARVE_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vid_en_i,
  input  logic [ADDRW-1:0] vid_addr_i,
  output logic [DATAW-1:0] vid_data_o,
  input  logic             s_wr_valid,
  output logic             s_wr_ready,
  input  logic [ADDRW-1:0] s_wr_addr,
  input  logic [DATAW-1:0] s_wr_data,
  input  logic             s_ar_valid,
  output logic             s_ar_ready,
  input  logic [ADDRW-1:0] s_ar_addr,
  output logic             m_r_valid,
  output logic [DATAW-1:0] m_r_data,
  output logic             bram_en_o,
  output logic             bram_we_o,
  output logic [ADDRW-1:0] bram_addr_o,
  output logic [DATAW-1:0] bram_wdata_o,
  input  logic [DATAW-1:0] bram_rdata_i,
  output logic             wr_starved_o,
  output logic             addr_err_o,
  output logic [15:0]      wr_cnt_o
);

  localparam int SCW = $clog2(STARVE_CYC + 1);
  localparam logic [ADDRW:0]  DEPTH_W = (ADDRW + 1)'(DEPTH);
  localparam logic [SCW-1:0]  STARVE_MAX = SCW'(STARVE_CYC);

  logic              last_ar;      // 1: last granted free slot went to aux
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_oor;
  logic [SCW-1:0]    starve_cnt;
  logic              addr_err_q;
  logic [15:0]       wr_cnt_q;

  logic slot_free;
  logic grant_wr;
  logic grant_ar;
  logic wr_in_range;
  logic ar_in_range;

  assign wr_in_range = ({1'b0, s_wr_addr} < DEPTH_W);
  assign ar_in_range = ({1'b0, s_ar_addr} < DEPTH_W);

  // Tie goes to whichever port did not win the previous granted free slot.
  assign slot_free = ~rst & ~vid_en_i;
  assign grant_wr  = slot_free & s_wr_valid & (~s_ar_valid | last_ar);
  assign grant_ar  = slot_free & s_ar_valid & (~s_wr_valid | ~last_ar);

  assign s_wr_ready = grant_wr;
  assign s_ar_ready = grant_ar;

  // Out-of-range accepts consume the slot but leave the BRAM idle.
  always_comb begin
    bram_en_o    = 1'b0;
    bram_we_o    = 1'b0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    if (!rst) begin
      if (vid_en_i) begin
        bram_en_o   = 1'b1;
        bram_addr_o = vid_addr_i;
      end else if (grant_wr) begin
        if (wr_in_range) begin
          bram_en_o    = 1'b1;
          bram_we_o    = 1'b1;
          bram_addr_o  = s_wr_addr;
          bram_wdata_o = s_wr_data;
        end
      end else if (grant_ar && ar_in_range) begin
        bram_en_o   = 1'b1;
        bram_addr_o = s_ar_addr;
      end
    end
  end

  assign vid_data_o = bram_rdata_i;

  // Response strobe lines up with the BRAM data of the accepted read.
  assign m_r_valid = tag_v[RD_LAT-1] & ~rst;
  assign m_r_data  = (m_r_valid && !tag_oor[RD_LAT-1]) ? bram_rdata_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ar    <= 1'b1;
      tag_v      <= '0;
      tag_oor    <= '0;
      starve_cnt <= '0;
      addr_err_q <= 1'b0;
      wr_cnt_q   <= '0;
    end else begin
      if (grant_wr) last_ar <= 1'b0;
      else if (grant_ar) last_ar <= 1'b1;

      tag_v[0]   <= grant_ar;
      tag_oor[0] <= grant_ar & ~ar_in_range;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_oor[i] <= tag_oor[i-1];
      end

      if (s_wr_valid && !grant_wr) begin
        if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SCW'(1);
      end else begin
        starve_cnt <= '0;
      end

      if ((grant_wr && !wr_in_range) || (grant_ar && !ar_in_range))
        addr_err_q <= 1'b1;

      if (grant_wr && wr_in_range) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign wr_starved_o = (starve_cnt == STARVE_MAX);
  assign addr_err_o   = addr_err_q;
  assign wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_img_bram_arb.sv
module tb_img_bram_arb;
  localparam int ADDRW = 17, DATAW = 24, DEPTH = 76800, RD_LAT = 2, STARVE_CYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vid_en_i = 1'b0;
  logic [ADDRW-1:0] vid_addr_i = '0;
  logic [DATAW-1:0] vid_data_o;
  logic s_wr_valid = 1'b0;
  logic s_wr_ready;
  logic [ADDRW-1:0] s_wr_addr = '0;
  logic [DATAW-1:0] s_wr_data = '0;
  logic s_ar_valid = 1'b0;
  logic s_ar_ready;
  logic [ADDRW-1:0] s_ar_addr = '0;
  logic m_r_valid;
  logic [DATAW-1:0] m_r_data;
  logic bram_en_o, bram_we_o;
  logic [ADDRW-1:0] bram_addr_o;
  logic [DATAW-1:0] bram_wdata_o;
  logic [DATAW-1:0] bram_rdata_i;
  logic wr_starved_o, addr_err_o;
  logic [15:0] wr_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  string phase = "reset";
  int step_no = 0;

  always #5 clk = ~clk;

  img_bram_arb #(.ADDRW(ADDRW), .DATAW(DATAW), .DEPTH(DEPTH), .RD_LAT(RD_LAT),
                 .STARVE_CYC(STARVE_CYC)) dut (
    .clk(clk), .rst(rst),
    .vid_en_i(vid_en_i), .vid_addr_i(vid_addr_i), .vid_data_o(vid_data_o),
    .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .m_r_valid(m_r_valid), .m_r_data(m_r_data),
    .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
    .bram_wdata_o(bram_wdata_o), .bram_rdata_i(bram_rdata_i),
    .wr_starved_o(wr_starved_o), .addr_err_o(addr_err_o), .wr_cnt_o(wr_cnt_o)
  );

  // BRAM model: preloaded with data = address, RD_LAT-stage read pipe.
  logic [DATAW-1:0] mem [0:DEPTH-1];
  logic [DATAW-1:0] rpipe [RD_LAT];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DATAW'(i);
  initial for (int i = 0; i < RD_LAT; i++) rpipe[i] = '0;
  always @(posedge clk) begin
    if (bram_en_o) begin
      if (bram_we_o) mem[bram_addr_o] <= bram_wdata_o;
      else rpipe[0] <= mem[bram_addr_o];
    end
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign bram_rdata_i = rpipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s step %0d: got %0h, expected %0h", phase, name, step_no, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    vid_en_i = 0; vid_addr_i = '0;
    s_wr_valid = 0; s_wr_addr = '0; s_wr_data = '0;
    s_ar_valid = 0; s_ar_addr = '0;
  endtask

  typedef struct {
    logic vid; logic [ADDRW-1:0] vaddr;
    logic wv; logic [ADDRW-1:0] waddr; logic [DATAW-1:0] wdata;
    logic av; logic [ADDRW-1:0] aaddr;
    logic e_wrdy, e_ardy, e_en, e_we;
    logic [ADDRW-1:0] e_addr; logic [DATAW-1:0] e_wdata;
    logic e_rv; logic [DATAW-1:0] e_rdata;
    logic e_err; logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(int vid, int vaddr, int wv, int waddr, int wdata, int av, int aaddr,
                              int wrdy, int ardy, int en, int we, int addr, int wd,
                              int rv, int rdata, int err, int cnt);
    vec_t v;
    v.vid = 1'(vid); v.vaddr = ADDRW'(vaddr);
    v.wv = 1'(wv); v.waddr = ADDRW'(waddr); v.wdata = DATAW'(wdata);
    v.av = 1'(av); v.aaddr = ADDRW'(aaddr);
    v.e_wrdy = 1'(wrdy); v.e_ardy = 1'(ardy); v.e_en = 1'(en); v.e_we = 1'(we);
    v.e_addr = ADDRW'(addr); v.e_wdata = DATAW'(wd);
    v.e_rv = 1'(rv); v.e_rdata = DATAW'(rdata);
    v.e_err = 1'(err); v.e_cnt = 16'(cnt);
    return v;
  endfunction

  // Reference model for the random phase.
  typedef struct { int due; logic [DATAW-1:0] d; } ret_t;
  logic [DATAW-1:0] ovr [int];

  function automatic logic [DATAW-1:0] ref_rd(int a);
    if (ovr.exists(a)) return ovr[a];
    return DATAW'(a);
  endfunction

  function automatic int pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return 'h100 + int'($urandom_range(0, 15));
    if (r <= 7) return DEPTH - 1 - int'($urandom_range(0, 3));
    if (r == 8) return DEPTH + int'($urandom_range(0, 3));
    return int'($urandom_range(DEPTH, 'h1FFFF));
  endfunction

  vec_t tbl [13];

  initial begin
    tbl[0]  = mk(1, 5, 1, 'h20, 'h111111, 1, 'h30,   0, 0, 1, 0, 5, 0,               0, 0,        0, 0);
    tbl[1]  = mk(0, 0, 1, 'h20, 'h111111, 1, 'h30,   1, 0, 1, 1, 'h20, 'h111111,     0, 0,        0, 0);
    tbl[2]  = mk(0, 0, 1, 'h20, 'h111111, 1, 'h30,   0, 1, 1, 0, 'h30, 0,            0, 0,        0, 1);
    tbl[3]  = mk(0, 0, 1, 'h20, 'h111111, 1, 'h30,   1, 0, 1, 1, 'h20, 'h111111,     0, 0,        0, 1);
    tbl[4]  = mk(0, 0, 1, 'h20, 'h111111, 1, 'h30,   0, 1, 1, 0, 'h30, 0,            1, 'h30,     0, 2);
    tbl[5]  = mk(0, 0, 1, 'h10, 'hABCDEF, 0, 0,      1, 0, 1, 1, 'h10, 'hABCDEF,     0, 0,        0, 2);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 'h10,             0, 1, 1, 0, 'h10, 0,            1, 'h30,     0, 3);
    tbl[7]  = mk(0, 0, 1, 76800, 'h555555, 0, 0,     1, 0, 0, 0, 0, 0,               0, 0,        0, 3);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 'h1FFFF,          0, 1, 0, 0, 0, 0,               1, 'hABCDEF, 1, 3);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 0,               0, 0,        1, 3);
    tbl[10] = mk(1, 7, 1, 'h40, 'h222222, 0, 0,      0, 0, 1, 0, 7, 0,               1, 0,        1, 3);
    tbl[11] = mk(0, 0, 1, 'h40, 'h222222, 0, 0,      1, 0, 1, 1, 'h40, 'h222222,     0, 0,        1, 3);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 0,               0, 0,        1, 4);

    // ---- Reset: outputs forced low even with all requests active
    rst = 1; vid_en_i = 1; vid_addr_i = 5; s_wr_valid = 1; s_ar_valid = 1;
    @(negedge clk);
    chk("rst_en", 32'(bram_en_o), 0);
    chk("rst_addr", 32'(bram_addr_o), 0);
    chk("rst_wrdy", 32'(s_wr_ready), 0);
    chk("rst_ardy", 32'(s_ar_ready), 0);
    tick(); tick();
    rst = 0; idle_in();
    @(negedge clk);
    chk("rv0", 32'(m_r_valid), 0);
    chk("rdata0", 32'(m_r_data), 0);
    chk("en0", 32'(bram_en_o), 0);
    chk("we0", 32'(bram_we_o), 0);
    chk("starved0", 32'(wr_starved_o), 0);
    chk("err0", 32'(addr_err_o), 0);
    chk("cnt0", 32'(wr_cnt_o), 0);
    tick();

    // ---- Table vectors
    phase = "table";
    for (int i = 0; i < 13; i++) begin
      step_no = i;
      vid_en_i = tbl[i].vid; vid_addr_i = tbl[i].vaddr;
      s_wr_valid = tbl[i].wv; s_wr_addr = tbl[i].waddr; s_wr_data = tbl[i].wdata;
      s_ar_valid = tbl[i].av; s_ar_addr = tbl[i].aaddr;
      @(negedge clk);
      chk("wr_ready", 32'(s_wr_ready), 32'(tbl[i].e_wrdy));
      chk("ar_ready", 32'(s_ar_ready), 32'(tbl[i].e_ardy));
      chk("bram_en", 32'(bram_en_o), 32'(tbl[i].e_en));
      chk("bram_we", 32'(bram_we_o), 32'(tbl[i].e_we));
      chk("bram_addr", 32'(bram_addr_o), 32'(tbl[i].e_addr));
      chk("bram_wdata", 32'(bram_wdata_o), 32'(tbl[i].e_wdata));
      chk("m_r_valid", 32'(m_r_valid), 32'(tbl[i].e_rv));
      chk("m_r_data", 32'(m_r_data), 32'(tbl[i].e_rdata));
      chk("addr_err", 32'(addr_err_o), 32'(tbl[i].e_err));
      chk("wr_cnt", 32'(wr_cnt_o), 32'(tbl[i].e_cnt));
      tick();
    end

    // ---- Video sweep: pass-through latency, requesters locked out
    phase = "video";
    for (int i = 0; i < 12; i++) begin
      step_no = i;
      vid_en_i = 1; vid_addr_i = (i < 10) ? ADDRW'(i) : '0;
      s_wr_valid = 1; s_wr_addr = 'h50; s_wr_data = 'h333333;
      s_ar_valid = 1; s_ar_addr = 'h51;
      @(negedge clk);
      chk("wr_ready", 32'(s_wr_ready), 0);
      chk("ar_ready", 32'(s_ar_ready), 0);
      chk("bram_addr", 32'(bram_addr_o), 32'(vid_addr_i));
      if (i >= RD_LAT) chk("vid_data", 32'(vid_data_o), 32'(i - RD_LAT));
      tick();
    end
    s_wr_valid = 0; s_ar_valid = 0;
    tick();

    // ---- Starvation
    phase = "starve";
    for (int k = 0; k < 20; k++) begin
      step_no = k;
      vid_en_i = 1; vid_addr_i = 'h3;
      s_wr_valid = 1; s_wr_addr = 'h50; s_wr_data = 'h333333;
      @(negedge clk);
      chk("starved", 32'(wr_starved_o), (k >= STARVE_CYC) ? 1 : 0);
      tick();
    end
    step_no = 20;
    vid_en_i = 0;
    @(negedge clk);
    chk("wr_ready", 32'(s_wr_ready), 1);
    chk("bram_we", 32'(bram_we_o), 1);
    chk("starved_hold", 32'(wr_starved_o), 1);
    tick();
    step_no = 21;
    s_wr_valid = 0;
    @(negedge clk);
    chk("starved_drop", 32'(wr_starved_o), 0);
    chk("wr_cnt", 32'(wr_cnt_o), 5);
    tick();

    // ---- Reset one cycle after an aux accept
    phase = "rst_mid";
    step_no = 0;
    s_ar_valid = 1; s_ar_addr = 'h10;
    @(negedge clk);
    chk("ar_ready", 32'(s_ar_ready), 1);
    tick();
    step_no = 1;
    rst = 1; vid_en_i = 1; vid_addr_i = 3; s_wr_valid = 1; s_ar_valid = 1;
    @(negedge clk);
    chk("bram_en", 32'(bram_en_o), 0);
    chk("bram_addr", 32'(bram_addr_o), 0);
    chk("wr_ready", 32'(s_wr_ready), 0);
    chk("ar_ready", 32'(s_ar_ready), 0);
    chk("m_r_valid", 32'(m_r_valid), 0);
    tick();
    rst = 0; idle_in();
    for (int k = 0; k < 4; k++) begin
      step_no = 2 + k;
      @(negedge clk);
      chk("m_r_valid", 32'(m_r_valid), 0);
      chk("m_r_data", 32'(m_r_data), 0);
      chk("addr_err", 32'(addr_err_o), 0);
      chk("wr_cnt", 32'(wr_cnt_o), 0);
      chk("bram_en", 32'(bram_en_o), 0);
      tick();
    end

    // ---- Random traffic against the reference model (fresh reset)
    phase = "random";
    rst = 1; tick(); rst = 0;
    begin
      logic m_last_ar;
      int m_scnt, m_cnt;
      logic m_err;
      ret_t rq[$];
      ret_t vq[$];
      logic gw, ga, win, ain, e_en, e_we, e_rv;
      logic [ADDRW-1:0] e_addr;
      logic [DATAW-1:0] e_wd, e_rd;
      ret_t r;
      m_last_ar = 1; m_scnt = 0; m_cnt = 0; m_err = 0;
      for (int t = 0; t < 3000; t++) begin
        step_no = t;
        vid_en_i = ($urandom_range(0, 3) == 0);
        vid_addr_i = ADDRW'('h100 + int'($urandom_range(0, 15)));
        if (!s_wr_valid && $urandom_range(0, 1) == 1) begin
          s_wr_valid = 1; s_wr_addr = ADDRW'(pick_addr()); s_wr_data = DATAW'($urandom);
        end
        if (!s_ar_valid && $urandom_range(0, 1) == 1) begin
          s_ar_valid = 1; s_ar_addr = ADDRW'(pick_addr());
        end
        @(negedge clk);
        gw  = !vid_en_i && s_wr_valid && (!s_ar_valid || m_last_ar);
        ga  = !vid_en_i && s_ar_valid && (!s_wr_valid || !m_last_ar);
        win = int'(s_wr_addr) < DEPTH;
        ain = int'(s_ar_addr) < DEPTH;
        e_en = vid_en_i || (gw && win) || (ga && ain);
        e_we = gw && win;
        e_addr = vid_en_i ? vid_addr_i : (gw && win) ? s_wr_addr : (ga && ain) ? s_ar_addr : '0;
        e_wd = (gw && win) ? s_wr_data : '0;
        e_rv = (rq.size() > 0) && (rq[0].due == t);
        e_rd = e_rv ? rq[0].d : '0;
        chk("wr_ready", 32'(s_wr_ready), 32'(gw));
        chk("ar_ready", 32'(s_ar_ready), 32'(ga));
        chk("bram_en", 32'(bram_en_o), 32'(e_en));
        chk("bram_we", 32'(bram_we_o), 32'(e_we));
        chk("bram_addr", 32'(bram_addr_o), 32'(e_addr));
        chk("bram_wdata", 32'(bram_wdata_o), 32'(e_wd));
        chk("m_r_valid", 32'(m_r_valid), 32'(e_rv));
        chk("m_r_data", 32'(m_r_data), 32'(e_rd));
        chk("starved", 32'(wr_starved_o), (m_scnt == STARVE_CYC) ? 1 : 0);
        chk("addr_err", 32'(addr_err_o), 32'(m_err));
        chk("wr_cnt", 32'(wr_cnt_o), 32'(m_cnt));
        if (vq.size() > 0 && vq[0].due == t) begin
          chk("vid_data", 32'(vid_data_o), 32'(vq[0].d));
          void'(vq.pop_front());
        end
        if (e_rv) void'(rq.pop_front());
        // model update for the coming edge
        if (vid_en_i) begin r.due = t + RD_LAT; r.d = ref_rd(int'(vid_addr_i)); vq.push_back(r); end
        if (ga) begin r.due = t + RD_LAT; r.d = ain ? ref_rd(int'(s_ar_addr)) : '0; rq.push_back(r); end
        if (gw && win) begin ovr[int'(s_wr_addr)] = s_wr_data; m_cnt = (m_cnt + 1) % 65536; end
        if ((gw && !win) || (ga && !ain)) m_err = 1;
        if (gw) m_last_ar = 0;
        else if (ga) m_last_ar = 1;
        if (s_wr_valid && !gw) m_scnt = (m_scnt < STARVE_CYC) ? m_scnt + 1 : STARVE_CYC;
        else m_scnt = 0;
        tick();
        if (gw) s_wr_valid = 0;
        if (ga) s_ar_valid = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
